conv_output_conditioner: RTL

Sits between the convolution engine and the PDM modulator. It consumes the 48-bit signed convolution result and re-times it to the 48 kHz audio strobe. It then scales it with a programmable arithmetic shift and saturates it to 16 bits. Finally it applies a click-free soft-mute gain ramp and presents a held 16-bit sample for level_in of pdm.

---
 rtl/conv_output_conditioner_if.sv | 35 +++
 rtl/conv_output_conditioner.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/conv_output_conditioner_if.sv
// ============================================================================
//  Module   : conv_output_conditioner_if
//  Brief    : Sample/control bundle between the convolution engine, the output
//             conditioner and the PDM level input.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface conv_output_conditioner_if #(
    parameter int IN_WIDTH = 48
);
    logic                       audio_trigger;
    logic                       sample_valid_in;
    logic [IN_WIDTH-1:0]        sample_in;
    logic [5:0]                 shift_in;
    logic                       mute_in;
    logic [15:0]                sample_out;
    logic                       sample_valid_out;
    logic                       clip_out;
    logic [15:0]                clip_count;
    logic [1:0]                 gain_state;

    // The master produces samples and control; the slave is the conditioner.
    modport master (
        output audio_trigger, sample_valid_in, sample_in, shift_in, mute_in,
        input  sample_out, sample_valid_out, clip_out, clip_count, gain_state
    );

    modport slave (
        input  audio_trigger, sample_valid_in, sample_in, shift_in, mute_in,
        output sample_out, sample_valid_out, clip_out, clip_count, gain_state
    );
endinterface

`default_nettype wire

// File: rtl/conv_output_conditioner.sv
// ============================================================================
//  Module   : conv_output_conditioner
//  Brief    : Re-times the convolution result to the audio strobe, shifts,
//             saturates to 16 bits and applies a soft-mute gain ramp.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_output_conditioner #(
    parameter int          IN_WIDTH  = 48,
    parameter logic [16:0] RAMP_STEP = 17'd64
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    conv_output_conditioner_if.slave bus
);

    localparam logic [1:0]  GS_MUTED     = 2'd0;
    localparam logic [1:0]  GS_RAMP_UP   = 2'd1;
    localparam logic [1:0]  GS_UNITY     = 2'd2;
    localparam logic [1:0]  GS_RAMP_DOWN = 2'd3;

    localparam logic [16:0] GAIN_UNITY   = 17'd32768;
    localparam logic [5:0]  SHIFT_MAX    = 6'(IN_WIDTH - 1);
    localparam logic [15:0] SAT_POS      = 16'h7FFF;
    localparam logic [15:0] SAT_NEG      = 16'h8000;
    localparam logic [15:0] COUNT_MAX    = 16'hFFFF;

    // Input capture
    logic [IN_WIDTH-1:0]        pending_q, pending_d;

    // Stage 1: shifted sample plus the gain that belongs to this trigger
    logic signed [IN_WIDTH-1:0] shifted_q, shifted_d;
    logic [16:0]                gain1_q, gain1_d;
    logic                       v1_q, v1_d;

    // Stage 2: saturated sample
    logic [15:0]                sat_q, sat_d;
    logic                       clip2_q, clip2_d;
    logic [16:0]                gain2_q, gain2_d;
    logic                       v2_q, v2_d;

    // Stage 3: outputs
    logic [15:0]                sample_out_q, sample_out_d;
    logic                       valid_out_q, valid_out_d;
    logic                       clip_out_q, clip_out_d;
    logic [15:0]                clip_count_q, clip_count_d;

    // Gain ramp
    logic [16:0]                gain_q, gain_d;
    logic [1:0]                 state_q, state_d;

    // Combinational helpers
    logic signed [IN_WIDTH-1:0] src;
    logic [5:0]                 shift_amt;
    logic [IN_WIDTH-16:0]       upper_bits;
    logic [33:0]                sat_ext;
    logic [33:0]                gain_ext;
    logic [33:0]                product;
    logic [17:0]                gain_sum;
    logic                       unused_product_bits;

    // Capture, shift and gain sampling
    always_comb begin
        pending_d = bus.sample_valid_in ? bus.sample_in : pending_q;
        // A sample arriving together with the trigger bypasses the register.
        src       = bus.sample_valid_in ? $signed(bus.sample_in) : $signed(pending_q);
        shift_amt = (bus.shift_in > SHIFT_MAX) ? SHIFT_MAX : bus.shift_in;
        shifted_d = shifted_q;
        gain1_d   = gain1_q;
        v1_d      = bus.audio_trigger;
        if (bus.audio_trigger) begin
            shifted_d = src >>> shift_amt;
            gain1_d   = gain_q;
        end
    end

    // Saturation
    always_comb begin
        upper_bits = shifted_q[IN_WIDTH-1:15];
        sat_d      = sat_q;
        clip2_d    = clip2_q;
        gain2_d    = gain2_q;
        v2_d       = v1_q;
        if (v1_q) begin
            gain2_d = gain1_q;
            if ((&upper_bits) || !(|upper_bits)) begin
                sat_d   = shifted_q[15:0];
                clip2_d = 1'b0;
            end else begin
                sat_d   = shifted_q[IN_WIDTH-1] ? SAT_NEG : SAT_POS;
                clip2_d = 1'b1;
            end
        end
    end

    // Gain multiply and output register
    always_comb begin
        sat_ext             = {{18{sat_q[15]}}, sat_q};
        gain_ext            = {17'd0, gain2_q};
        product             = sat_ext * gain_ext;
        unused_product_bits = ^{product[33:31], product[14:0]};
        sample_out_d        = sample_out_q;
        valid_out_d         = v2_q;
        clip_out_d          = v2_q & clip2_q;
        clip_count_d        = clip_count_q;
        if (v2_q) begin
            // Bits [30:15] are the floor of product/32768 and always fit.
            sample_out_d = product[30:15];
            if (clip2_q && (clip_count_q != COUNT_MAX)) begin
                clip_count_d = clip_count_q + 16'd1;
            end
        end
    end

    // Soft-mute gain FSM, advanced only on the audio strobe
    always_comb begin
        gain_sum = {1'b0, gain_q} + {1'b0, RAMP_STEP};
        gain_d   = gain_q;
        state_d  = state_q;
        if (bus.audio_trigger) begin
            case (state_q)
                GS_MUTED: begin
                    gain_d = 17'd0;
                    if (!bus.mute_in) state_d = GS_RAMP_UP;
                end
                GS_RAMP_UP: begin
                    if (bus.mute_in) begin
                        state_d = GS_RAMP_DOWN;
                    end else if (gain_sum >= {1'b0, GAIN_UNITY}) begin
                        gain_d  = GAIN_UNITY;
                        state_d = GS_UNITY;
                    end else begin
                        gain_d  = gain_sum[16:0];
                    end
                end
                GS_UNITY: begin
                    gain_d = GAIN_UNITY;
                    if (bus.mute_in) state_d = GS_RAMP_DOWN;
                end
                default: begin
                    if (!bus.mute_in) begin
                        state_d = GS_RAMP_UP;
                    end else if (gain_q <= RAMP_STEP) begin
                        gain_d  = 17'd0;
                        state_d = GS_MUTED;
                    end else begin
                        gain_d  = gain_q - RAMP_STEP;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pending_q    <= '0;
            shifted_q    <= '0;
            gain1_q      <= '0;
            v1_q         <= 1'b0;
            sat_q        <= '0;
            clip2_q      <= 1'b0;
            gain2_q      <= '0;
            v2_q         <= 1'b0;
            sample_out_q <= '0;
            valid_out_q  <= 1'b0;
            clip_out_q   <= 1'b0;
            clip_count_q <= '0;
            gain_q       <= '0;
            state_q      <= GS_MUTED;
        end else begin
            pending_q    <= pending_d;
            shifted_q    <= shifted_d;
            gain1_q      <= gain1_d;
            v1_q         <= v1_d;
            sat_q        <= sat_d;
            clip2_q      <= clip2_d;
            gain2_q      <= gain2_d;
            v2_q         <= v2_d;
            sample_out_q <= sample_out_d;
            valid_out_q  <= valid_out_d;
            clip_out_q   <= clip_out_d;
            clip_count_q <= clip_count_d;
            gain_q       <= gain_d;
            state_q      <= state_d;
        end
    end

    assign bus.sample_out       = sample_out_q;
    assign bus.sample_valid_out = valid_out_q;
    assign bus.clip_out         = clip_out_q;
    assign bus.clip_count       = clip_count_q;
    assign bus.gain_state       = state_q;

endmodule

`default_nettype wire
